// File: rtl/epic_hero_pkg.sv
// Shared definitions for the target hit judge.
// Holds the FSM state encoding, the target/score/streak widths and the
// index-to-one-hot decode used both for the target LEDs and hit matching.
package epic_hero_pkg;

  localparam int NUM_TARGETS = 10;
  localparam int SCORE_W     = 32;
  localparam int STREAK_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    ARMED,
    RESULT,
    GAP
  } state_t;

  // Decode a target index into a one-hot target mask; out-of-range -> 0.
  function automatic logic [NUM_TARGETS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_TARGETS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx == 4'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for the player buttons.
// Ports:
//   clock  - sole clock
//   reset  - synchronous active-high reset
//   btn    - button levels, already synchronised to clock
//   edges  - one-cycle mask of buttons that rose since the previous cycle
// The history register resets to all ones so a button already held
// down when reset is released does not register as a fresh press.
module btn_edge_detect
  import epic_hero_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_TARGETS-1:0] btn,
  output logic [NUM_TARGETS-1:0] edges
);

  logic [NUM_TARGETS-1:0] btn_q;

  always_ff @(posedge clock) begin
    if (reset) btn_q <= '1;
    else       btn_q <= btn;
  end

  assign edges = btn & ~btn_q;

endmodule

// File: rtl/target_hit_judge.sv
// Whack-a-mole style judge: arms one of ten targets, waits for the player to
// press the matching button within a window, then scores the result.
// Ports:
//   clock, reset  - sole clock, synchronous active-high reset
//   enable        - game running; low returns to IDLE, score/streak held
//   target_in     - free-running target index (0-9 valid)
//   btn           - player buttons (levels, synchronised)
//   target_led    - one-hot lit target, zero when nothing is armed
//   hit_pulse     - one-cycle pulse on a scored hit
//   miss_pulse    - one-cycle pulse on a miss
//   score         - running score, starts at 1 (used as generator modulus)
//   streak        - consecutive hits, saturating
// Build option: define TARGET_JUDGE_STREAK_EN to award 2 points for a hit
// made while the streak is already 4 or more.
module target_hit_judge
  import epic_hero_pkg::*;
#(
  parameter int WINDOW_CYCLES = 25000000,
  parameter int GAP_CYCLES    = 5000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             target_in,
  input  logic [NUM_TARGETS-1:0] btn,
  output logic [NUM_TARGETS-1:0] target_led,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic [STREAK_W-1:0]    streak
);

  state_t                 state;
  logic [3:0]             idx;
  logic [31:0]            win_cnt;
  logic [31:0]            gap_cnt;
  logic [NUM_TARGETS-1:0] edges;
  logic [NUM_TARGETS-1:0] target_mask;
  logic                   edge_hit;
  logic                   edge_bad;
  logic                   timeout;
  logic                   bonus;
  logic [SCORE_W:0]       score_sum;
  logic [SCORE_W-1:0]     score_hit;
  logic [STREAK_W-1:0]    streak_inc;

  btn_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .edges (edges)
  );

  assign target_mask = onehot(idx);

  // A hit needs the target bit and nothing else; any stray edge is a miss,
  // even when it lands together with the correct button.
  assign edge_hit = (edges != '0) && (edges == target_mask);
  assign edge_bad = (edges != '0) && (edges != target_mask);
  assign timeout  = (win_cnt == 32'(WINDOW_CYCLES - 1));

`ifdef TARGET_JUDGE_STREAK_EN
  assign bonus = (streak >= STREAK_W'(4));
`else
  assign bonus = 1'b0;
`endif

  // One extra bit catches the carry so the score can pin at all ones.
  assign score_sum  = {1'b0, score} + (bonus ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
  assign score_hit  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign streak_inc = (streak == '1) ? streak : streak + STREAK_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      win_cnt    <= '0;
      gap_cnt    <= '0;
      target_led <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= SCORE_W'(1);
      streak     <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        target_led <= '0;
        win_cnt    <= '0;
        gap_cnt    <= '0;
      end else begin
        case (state)
          IDLE: state <= SAMPLE;
          SAMPLE: begin
            // Invalid indices are simply skipped; the generator keeps running.
            if (target_in < 4'(NUM_TARGETS)) begin
              idx        <= target_in;
              target_led <= onehot(target_in);
              win_cnt    <= '0;
              state      <= ARMED;
            end
          end
          ARMED: begin
            // Edge check comes before timeout so a press in the last window
            // cycle still scores.
            if (edge_hit) begin
              hit_pulse  <= 1'b1;
              score      <= score_hit;
              streak     <= streak_inc;
              target_led <= '0;
              state      <= RESULT;
            end else if (edge_bad || timeout) begin
              miss_pulse <= 1'b1;
              streak     <= '0;
              target_led <= '0;
              state      <= RESULT;
            end else begin
              win_cnt <= win_cnt + 32'd1;
            end
          end
          RESULT: begin
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? SAMPLE : GAP;
          end
          GAP: begin
            if (gap_cnt == 32'(GAP_CYCLES - 1)) state <= SAMPLE;
            else                                 gap_cnt <= gap_cnt + 32'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_target_hit_judge.sv
// Randomised scoreboard bench for target_hit_judge (WINDOW=8, GAP=2).
// The driver plays rounds and pushes the predicted outcome; a monitor pops
// and compares whenever the judge pulses hit or miss.
module tb_target_hit_judge;
  localparam int W = 8;
  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] target_in;
  logic [9:0] btn;
  logic [9:0] target_led;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [31:0] score;
  logic [7:0]  streak;

  always #5 clock = ~clock;

  target_hit_judge #(.WINDOW_CYCLES(W), .GAP_CYCLES(G)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .target_in  (target_in),
    .btn        (btn),
    .target_led (target_led),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .streak     (streak)
  );

  typedef struct {
    bit          hit;
    logic [31:0] score;
    logic [7:0]  streak;
  } exp_t;

  exp_t   sbq[$];
  longint m_score;
  int     m_streak;
  int     tests = 0;
  int     fails = 0;

  function automatic void model_reset();
    m_score  = 1;
    m_streak = 0;
  endfunction

  // Reference rules: hit adds 1 (2 with bonus when streak>=4), score
  // saturates at 2^32-1, streak saturates at 255; miss clears streak.
  function automatic void push(bit hit);
    exp_t e;
    if (hit) begin
      longint inc = 1;
`ifdef TARGET_JUDGE_STREAK_EN
      if (m_streak >= 4) inc = 2;
`endif
      m_score = m_score + inc;
      if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
      if (m_streak < 255) m_streak++;
    end else begin
      m_streak = 0;
    end
    e.hit    = hit;
    e.score  = m_score[31:0];
    e.streak = m_streak[7:0];
    sbq.push_back(e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the oldest predicted outcome.
  always @(negedge clock) begin
    if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
      exp_t e;
      check("pulse_exclusive", 64'(hit_pulse & miss_pulse), 64'd0);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b with no outcome pending", hit_pulse, miss_pulse);
      end else begin
        e = sbq.pop_front();
        check("outcome_is_hit", 64'(hit_pulse), 64'(e.hit));
        check("score", 64'(score), 64'(e.score));
        check("streak", 64'(streak), 64'(e.streak));
        check("led_dark_in_result", 64'(target_led), 64'd0);
      end
    end
  end

  task automatic wait_led(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (target_led !== 10'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present a few invalid indices, then v, and wait for the target to light.
  task automatic arm(input int v, input int n_invalid, output bit ok);
    for (int i = 0; i < n_invalid; i++) begin
      target_in = 4'($urandom_range(10, 15));
      @(negedge clock);
    end
    target_in = 4'(v);
    wait_led(ok);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL arm_timeout: target %0d never lit, led=%0h", v, target_led);
    end else begin
      check("target_led", 64'(target_led), 64'(10'd1 << v));
    end
  endtask

  // Called at the negedge of the first lit cycle (window counter 0).
  // kind: 0 correct press, 1 wrong press, 2 correct+wrong, 3 no press,
  //       4 enable drop, 5 reset mid-window.
  task automatic act(input int v, input int kind, input int k);
    logic [9:0] oh;
    logic [9:0] wrong;
    int w;
    int n;
    oh = 10'd1 << v;
    w  = (v + 1 + $urandom_range(0, 8)) % 10;
    wrong = 10'd1 << w;
    case (kind)
      0, 1, 2: begin
        for (int i = 0; i < k; i++) @(negedge clock);
        push(kind == 0);
        btn = btn | ((kind == 1) ? wrong : (kind == 2) ? (oh | wrong) : oh);
        @(negedge clock);
        check("result_latency", 64'({hit_pulse, miss_pulse}), (kind == 0) ? 64'd2 : 64'd1);
        btn = '0;
      end
      3: begin
        push(1'b0);
        n = 1;
        for (int i = 0; i < 30; i++) begin
          @(negedge clock);
          if (target_led === 10'd0) break;
          n++;
        end
        check("window_len", 64'(n), 64'(W));
        check("timeout_miss", 64'(miss_pulse), 64'd1);
        btn = '0;
      end
      4: begin
        for (int i = 0; i < k; i++) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("disable_led", 64'(target_led), 64'd0);
        check("disable_no_pulse", 64'({hit_pulse, miss_pulse}), 64'd0);
        check("disable_score_held", 64'(score), 64'(m_score));
        @(negedge clock);
        enable = 1'b1;
      end
      default: begin
        for (int i = 0; i < k; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("rst_led", 64'(target_led), 64'd0);
        check("rst_no_pulse", 64'({hit_pulse, miss_pulse}), 64'd0);
        check("rst_score", 64'(score), 64'd1);
        check("rst_streak", 64'(streak), 64'd0);
      end
    endcase
  endtask

  task automatic round(input int v, input int kind, input int k);
    bit ok;
    arm(v, $urandom_range(0, 3), ok);
    if (ok) act(v, kind, k);
  endtask

  initial begin
    bit ok;
    int kind;
    model_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    target_in = 4'd12;
    btn       = 10'h020;  // button 5 held through reset
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_led", 64'(target_led), 64'd0);
    check("reset_pulses", 64'({hit_pulse, miss_pulse}), 64'd0);
    check("reset_score", 64'(score), 64'd1);
    check("reset_streak", 64'(streak), 64'd0);

    // Invalid index must keep the judge dark in SAMPLE.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("invalid_index_dark", 64'(target_led), 64'd0);
    end
    target_in = 4'd5;
    wait_led(ok);
    check("armed_target5", 64'(target_led), 64'h020);
    // Held button never produces an edge -> window timeout.
    act(5, 3, 0);

    round(3, 0, 2);      // hit: score 1->2, streak 1
    round(7, 2, 1);      // target and stray button together: miss
    round(0, 0, W - 1);  // press in the final window cycle still hits
    for (int i = 0; i < 6; i++) round($urandom_range(0, 9), 0, $urandom_range(0, W - 1));

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 9);
      if (kind > 5) kind = 0;
      round($urandom_range(0, 9), kind, (kind >= 4) ? $urandom_range(0, W - 3) : $urandom_range(0, W - 1));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
